// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package arb_pkg;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
      logic  is_load;
   } own_t;

   localparam int CONFLICT_CNT_W = 16;

endpackage

// File: rtl/prio_sel.sv
// Two-input fixed-priority selector; boost hands priority to the low input.
module prio_sel (
   input  logic req_hi,
   input  logic req_lo,
   input  logic boost,
   output logic gnt_hi,
   output logic gnt_lo
);

   assign gnt_lo = req_lo & (~req_hi | boost);
   assign gnt_hi = req_hi & ~gnt_lo;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port wins, starving fetch gets one grant.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req,
   input  logic [ADDR_W-1:0]         i_addr,
   output logic                      i_gnt,
   output logic                      i_rvalid,
   output logic [DATA_W-1:0]         i_rdata,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [ADDR_W-1:0]         d_addr,
   input  logic [DATA_W-1:0]         d_wdata,
   output logic                      d_gnt,
   output logic                      d_rvalid,
   output logic [DATA_W-1:0]         d_rdata,
   output logic                      m_en,
   output logic                      m_we,
   output logic [ADDR_W-1:0]         m_addr,
   output logic [DATA_W-1:0]         m_wdata,
   input  logic [DATA_W-1:0]         m_rdata,
   output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

   logic                      sel_i;
   logic                      sel_d;
   logic                      fetch_starve;
   logic [3:0]                wait_cnt;
   logic [CONFLICT_CNT_W-1:0] cnt;
   own_t                      own;

   assign fetch_starve = (wait_cnt >= 4'(MAX_WAIT));

   prio_sel u_prio (
      .req_hi (d_req),
      .req_lo (i_req),
      .boost  (fetch_starve),
      .gnt_hi (sel_d),
      .gnt_lo (sel_i)
   );

   assign i_gnt = sel_i & ~rst;
   assign d_gnt = sel_d & ~rst;
   assign m_en  = i_gnt | d_gnt;
   assign m_we  = d_gnt & d_we;

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      if (d_gnt) begin
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (i_gnt) begin
         m_addr  = i_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         own      <= '0;
         wait_cnt <= '0;
         cnt      <= '0;
      end else begin
         own.valid   <= m_en;
         own.port    <= d_gnt ? PORT_D : PORT_I;
         own.is_load <= d_gnt & ~d_we;
         if (i_req & ~i_gnt)
            wait_cnt <= wait_cnt + 4'd1;
         else
            wait_cnt <= '0;
         if (i_req & d_req & ~&cnt)
            cnt <= cnt + CONFLICT_CNT_W'(1);
      end
   end

   // Responses and the counter read as zero for the whole reset window.
   assign i_rvalid     = own.valid & (own.port == PORT_I) & ~rst;
   assign d_rvalid     = own.valid & (own.port == PORT_D) & ~rst;
   assign i_rdata      = i_rvalid ? m_rdata : '0;
   assign d_rdata      = (d_rvalid & own.is_load) ? m_rdata : '0;
   assign conflict_cnt = rst ? '0 : cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: behavioural arbiter model plus directed literal checks.
module tb_mem_port_arbiter;

   localparam int MW = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = '0;
   logic [15:0] conflict_cnt;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Memory macro driven by the DUT's memory port.
   bit [31:0] mem [256];
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we) mem[m_addr[7:0]] <= m_wdata;
         else      m_rdata <= mem[m_addr[7:0]];
      end
   end

   // Stimulus for the next cycle.
   logic        s_rst, s_ireq, s_dreq, s_dwe;
   logic [31:0] s_iaddr, s_daddr, s_dwdata;

   // Model state.
   bit [31:0]   ref_mem [256];
   int unsigned m_wait, m_conf;
   bit          r_valid, r_port_i, r_load;
   bit [31:0]   r_data;
   bit          ei, ed;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      bit        ev_i, ev_d;
      bit [31:0] ea, ew;
      @(negedge clk);
      rst = s_rst; i_req = s_ireq; i_addr = s_iaddr;
      d_req = s_dreq; d_we = s_dwe; d_addr = s_daddr; d_wdata = s_dwdata;
      #1;
      ei = !s_rst && s_ireq && (!s_dreq || m_wait >= MW);
      ed = !s_rst && s_dreq && !ei;
      ea = ei ? s_iaddr : (ed ? s_daddr : 32'h0);
      ew = ed ? s_dwdata : 32'h0;
      ev_i = !s_rst && r_valid && r_port_i;
      ev_d = !s_rst && r_valid && !r_port_i;
      chk("i_gnt", 64'(i_gnt), 64'(ei));
      chk("d_gnt", 64'(d_gnt), 64'(ed));
      chk("m_en", 64'(m_en), 64'(ei | ed));
      chk("m_we", 64'(m_we), 64'(ed & s_dwe));
      chk("m_addr", 64'(m_addr), 64'(ea));
      chk("m_wdata", 64'(m_wdata), 64'(ew));
      chk("i_rvalid", 64'(i_rvalid), 64'(ev_i));
      chk("i_rdata", 64'(i_rdata), 64'(ev_i ? r_data : 32'h0));
      chk("d_rvalid", 64'(d_rvalid), 64'(ev_d));
      chk("d_rdata", 64'(d_rdata),
          64'((ev_d && r_load) ? r_data : 32'h0));
      chk("conflict_cnt", 64'(conflict_cnt),
          64'(s_rst ? 0 : m_conf));
      if (s_rst) begin
         m_wait = 0; m_conf = 0; r_valid = 0;
      end else begin
         m_wait = (s_ireq && !ei) ? m_wait + 1 : 0;
         if (s_ireq && s_dreq && m_conf < 65535) m_conf++;
         r_valid  = ei || ed;
         r_port_i = ei;
         r_load   = ed && !s_dwe;
         r_data   = ei ? ref_mem[s_iaddr[7:0]] :
                    (r_load ? ref_mem[s_daddr[7:0]] : 32'h0);
         if (ed && s_dwe) ref_mem[s_daddr[7:0]] = s_dwdata;
      end
   endtask

   task automatic idle();
      s_rst = 0; s_ireq = 0; s_dreq = 0; s_dwe = 0;
      s_iaddr = 0; s_daddr = 0; s_dwdata = 0;
   endtask

   initial begin
      m_wait = 0; m_conf = 0; r_valid = 0; r_port_i = 0;
      r_load = 0; r_data = 0;
      idle(); s_rst = 1;
      tick(); tick();
      chk("rst_conf", 64'(conflict_cnt), 64'h0);
      idle();

      // Preload 0x10 through the data port, then a lone fetch.
      s_dreq = 1; s_dwe = 1; s_daddr = 32'h10; s_dwdata = 32'hDEADBEEF;
      tick();
      idle(); s_ireq = 1; s_iaddr = 32'h10;
      tick();
      chk("lone_i_gnt", 64'(i_gnt), 64'h1);
      chk("lone_m_addr", 64'(m_addr), 64'h10);
      idle(); tick();
      chk("lone_i_rdata", 64'(i_rdata), 64'hDEADBEEF);
      chk("lone_d_rvalid", 64'(d_rvalid), 64'h0);

      // Conflict: data, data, data, fetch, data.
      s_rst = 1; tick(); idle();
      s_ireq = 1; s_iaddr = 32'h20; s_dreq = 1; s_daddr = 32'h30;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("conf_i_gnt", 64'(i_gnt), (k == 3) ? 64'h1 : 64'h0);
         chk("conf_d_gnt", 64'(d_gnt), (k == 3) ? 64'h0 : 64'h1);
         chk("conf_cnt", 64'(conflict_cnt), 64'(k));
      end
      chk("pin_wait", 64'(m_wait), 64'h1);
      chk("pin_conf", 64'(m_conf), 64'h5);

      // Store then load the same word.
      idle(); s_dreq = 1; s_dwe = 1; s_daddr = 32'h40;
      s_dwdata = 32'h12345678;
      tick();
      chk("st_m_we", 64'(m_we), 64'h1);
      idle(); s_dreq = 1; s_daddr = 32'h40;
      tick();
      chk("st_d_rvalid", 64'(d_rvalid), 64'h1);
      chk("st_d_rdata", 64'(d_rdata), 64'h0);
      idle(); tick();
      chk("ld_d_rdata", 64'(d_rdata), 64'h12345678);

      // Back-to-back alternation.
      s_ireq = 1; s_iaddr = 32'h10; tick();
      idle(); s_dreq = 1; s_daddr = 32'h40; tick();
      chk("alt_i_rvalid", 64'(i_rvalid), 64'h1);
      chk("alt_d_rvalid1", 64'(d_rvalid), 64'h0);
      idle(); tick();
      chk("alt_d_rvalid2", 64'(d_rvalid), 64'h1);
      chk("alt_i_rvalid2", 64'(i_rvalid), 64'h0);

      // Reset the cycle after a fetch is accepted.
      s_ireq = 1; s_iaddr = 32'h10; s_dreq = 1; s_daddr = 32'h44;
      s_rst = 0;
      for (int k = 0; k < MW; k++) tick();
      idle(); s_ireq = 1; s_iaddr = 32'h10; tick();
      s_rst = 1; s_dreq = 1; tick();
      chk("rmid_i_rvalid", 64'(i_rvalid), 64'h0);
      chk("rmid_i_gnt", 64'(i_gnt), 64'h0);
      chk("rmid_m_en", 64'(m_en), 64'h0);
      chk("rmid_conf", 64'(conflict_cnt), 64'h0);
      s_rst = 0; tick();
      chk("rrel_d_gnt", 64'(d_gnt), 64'h1);
      chk("rrel_conf", 64'(conflict_cnt), 64'h0);

      // Randomised traffic with occasional resets.
      idle();
      for (int n = 0; n < 3000; n++) begin
         s_rst = ($urandom_range(0, 63) == 0);
         if (!s_ireq && $urandom_range(0, 1) == 1) begin
            s_ireq = 1; s_iaddr = $urandom;
         end
         if (!s_dreq && $urandom_range(0, 1) == 1) begin
            s_dreq = 1; s_dwe = $urandom_range(0, 1) == 1;
            s_daddr = $urandom; s_dwdata = $urandom;
         end
         tick();
         if (ei) s_ireq = 0;
         if (ed) s_dreq = 0;
      end

      // Saturation of the conflict counter.
      s_rst = 1; tick();
      idle(); s_ireq = 1; s_iaddr = 32'h8; s_dreq = 1; s_daddr = 32'hC;
      for (int n = 0; n < 32'h10004; n++) tick();
      chk("sat_conf", 64'(conflict_cnt), 64'hFFFF);
      chk("pin_sat", 64'(m_conf), 64'd65535);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
